// File: rtl/traffic_light_fsm.sv
// Six-phase intersection controller that hands each phase length to an external interval timer.
// Define TLC_WALK_EN to build the pedestrian WALK phase and its sticky request latch.
module traffic_light_fsm #(
  parameter logic [3:0] T_BASE = 4'd6,
  parameter logic [3:0] T_EXT  = 4'd3,
  parameter logic [3:0] T_YEL  = 4'd2
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       sensor,
  input  logic       walk_req,
  input  logic       expired,
  output logic [3:0] interval,
  output logic       start_timer,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk
);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Extended side green saturates instead of wrapping to a short interval.
  localparam logic [4:0] SUM_LONG = {1'b0, T_BASE} + {1'b0, T_EXT};
  localparam logic [3:0] T_LONG   = SUM_LONG[4] ? 4'd15 : SUM_LONG[3:0];

  typedef enum logic [2:0] {
    MAIN_GB = 3'd0,
    MAIN_GE = 3'd1,
    MAIN_Y  = 3'd2,
`ifdef TLC_WALK_EN
    WALK    = 3'd3,
`endif
    SIDE_G  = 3'd4,
    SIDE_Y  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] interval_q, interval_d;
  logic       start_q, start_d;
  logic       init_q;
  logic       advance;

  // A strobe arriving while the timer is being (re)started belongs to the old phase.
  assign advance = expired & ~start_q & ~init_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= MAIN_GB;
      interval_q <= T_BASE;
      start_q    <= 1'b0;
      init_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      start_q    <= start_d;
      init_q     <= 1'b0;
    end
  end

`ifdef TLC_WALK_EN
  logic walk_latch_q, walk_latch_d;

  // A request coinciding with WALK entry must survive the clear.
  assign walk_latch_d = walk_req |
                        (walk_latch_q & ~((state_d == WALK) & (state_q != WALK)));

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      walk_latch_q <= 1'b0;
    end else begin
      walk_latch_q <= walk_latch_d;
    end
  end
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
`endif

  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    start_d    = init_q;
    case (state_q)
      MAIN_GB: if (advance) begin
        state_d    = MAIN_GE;
        interval_d = sensor ? T_EXT : T_BASE;
        start_d    = 1'b1;
      end
      MAIN_GE: if (advance) begin
        state_d    = MAIN_Y;
        interval_d = T_YEL;
        start_d    = 1'b1;
      end
      MAIN_Y: if (advance) begin
`ifdef TLC_WALK_EN
        if (walk_latch_q) begin
          state_d    = WALK;
          interval_d = T_EXT;
        end else
`endif
        begin
          state_d    = SIDE_G;
          interval_d = sensor ? T_LONG : T_BASE;
        end
        start_d = 1'b1;
      end
`ifdef TLC_WALK_EN
      WALK: if (advance) begin
        state_d    = SIDE_G;
        interval_d = sensor ? T_LONG : T_BASE;
        start_d    = 1'b1;
      end
`endif
      SIDE_G: if (advance) begin
        state_d    = SIDE_Y;
        interval_d = T_YEL;
        start_d    = 1'b1;
      end
      SIDE_Y: if (advance) begin
        state_d    = MAIN_GB;
        interval_d = T_BASE;
        start_d    = 1'b1;
      end
      default: begin
        state_d    = MAIN_GB;
        interval_d = T_BASE;
        start_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    main_lights = LAMP_R;
    side_lights = LAMP_R;
    walk        = 1'b0;
    case (state_q)
      MAIN_GB, MAIN_GE: main_lights = LAMP_G;
      MAIN_Y:           main_lights = LAMP_Y;
`ifdef TLC_WALK_EN
      WALK:             walk = 1'b1;
`endif
      SIDE_G:           side_lights = LAMP_G;
      SIDE_Y:           side_lights = LAMP_Y;
      default:          walk = 1'b0;
    endcase
  end

  assign interval    = interval_q;
  assign start_timer = start_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: two instances (default timing and a saturating one) driven by a
// randomized timer/sensor/pedestrian environment and compared against a phase-level model.
module tb_traffic_light_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset_n, sensor, walk_req, expired;
  logic [3:0] interval_a, interval_b;
  logic       start_a, start_b, walk_a, walk_b;
  logic [2:0] main_a, side_a, main_b, side_b;

  traffic_light_fsm dut_a (
    .clk(clk), .Reset_n(Reset_n), .sensor(sensor), .walk_req(walk_req), .expired(expired),
    .interval(interval_a), .start_timer(start_a), .main_lights(main_a),
    .side_lights(side_a), .walk(walk_a)
  );

  traffic_light_fsm #(.T_BASE(4'd12), .T_EXT(4'd9), .T_YEL(4'd2)) dut_b (
    .clk(clk), .Reset_n(Reset_n), .sensor(sensor), .walk_req(walk_req), .expired(expired),
    .interval(interval_b), .start_timer(start_b), .main_lights(main_b),
    .side_lights(side_b), .walk(walk_b)
  );

`ifdef TLC_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif

  // Phase numbering: 0 main green base, 1 main green ext, 2 main yellow, 3 walk, 4 side green, 5 side yellow.
  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;
  bit lat = 1'b0;
  int exp_int_a = 6;
  int exp_int_b = 12;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int next_ph(input int p, input bit l);
    case (p)
      0: return 1;
      1: return 2;
      2: return (WALK_EN && l) ? 3 : 4;
      3: return 4;
      4: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int phase_len(input int p, input bit s, input int tb, input int te, input int ty);
    int long_g;
    long_g = (tb + te > 15) ? 15 : tb + te;
    case (p)
      0: return tb;
      1: return s ? te : tb;
      2: return ty;
      3: return te;
      4: return s ? long_g : tb;
      default: return ty;
    endcase
  endfunction

  // Lamps as {R,Y,G}: 4 = red, 2 = yellow, 1 = green.
  function automatic int main_lamp(input int p);
    if (p <= 1) return 1;
    if (p == 2) return 2;
    return 4;
  endfunction

  function automatic int side_lamp(input int p);
    if (p == 4) return 1;
    if (p == 5) return 2;
    return 4;
  endfunction

  task automatic check_state(input string tag, input bit exp_start);
    check_val({tag, ".start_a"}, int'(start_a), int'(exp_start));
    check_val({tag, ".start_b"}, int'(start_b), int'(exp_start));
    check_val({tag, ".interval_a"}, int'(interval_a), exp_int_a);
    check_val({tag, ".interval_b"}, int'(interval_b), exp_int_b);
    check_val({tag, ".main_a"}, int'(main_a), main_lamp(ph));
    check_val({tag, ".side_a"}, int'(side_a), side_lamp(ph));
    check_val({tag, ".walk_a"}, int'(walk_a), (ph == 3) ? 1 : 0);
    check_val({tag, ".main_b"}, int'(main_b), main_lamp(ph));
    check_val({tag, ".side_b"}, int'(side_b), side_lamp(ph));
    check_val({tag, ".walk_b"}, int'(walk_b), (ph == 3) ? 1 : 0);
    check_val({tag, ".exclusive"}, ((main_a[1:0] != 2'b00) && (side_a[1:0] != 2'b00)) ? 1 : 0, 0);
  endtask

  // Called just after the edge that starts the entry cycle.
  task automatic expect_entry(input string tag);
    @(negedge clk);
    check_state({tag, ".entry"}, 1'b1);
    $display("tb: %s phase=%0d interval_a=%0d interval_b=%0d main=%b side=%b walk=%b",
             tag, ph, interval_a, interval_b, main_a, side_a, walk_a);
    @(posedge clk); #1;
    expired = 1'b0;
    @(negedge clk);
    check_state({tag, ".hold"}, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_walk();
    walk_req = 1'b1;
    if (WALK_EN) lat = 1'b1;
    @(posedge clk); #1;
    walk_req = 1'b0;
  endtask

  // sens_sel: 0/1 force sensor, 2 random. stale keeps expired high through the start cycle.
  task automatic timer_cycle(input string tag, input int sens_sel, input bit stale, input bit rnd_walk);
    int k;
    k = int'($urandom_range(0, 3));
    for (int i = 0; i < k; i++) begin
      sensor = (sens_sel == 2) ? 1'($urandom_range(0, 1)) : sens_sel[0];
      if (rnd_walk && $urandom_range(0, 3) == 0) begin
        walk_req = 1'b1;
        if (WALK_EN) lat = 1'b1;
      end
      @(posedge clk); #1;
      walk_req = 1'b0;
    end
    sensor  = (sens_sel == 2) ? 1'($urandom_range(0, 1)) : sens_sel[0];
    expired = 1'b1;
    ph = next_ph(ph, lat);
    if (ph == 3) lat = 1'b0;
    exp_int_a = phase_len(ph, sensor, 6, 3, 2);
    exp_int_b = phase_len(ph, sensor, 12, 9, 2);
    @(posedge clk); #1;
    expired = stale;
    expect_entry(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sensor   = 1'b0;
    walk_req = 1'b0;
    expired  = 1'b0;
    Reset_n  = 1'b1;
    #1 Reset_n = 1'b0;
    #2;
    check_state("reset", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_state("reset_hold", 1'b0);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    expect_entry("release");

    for (int i = 0; i < 5; i++) timer_cycle("sensor0", 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) timer_cycle("sensor1", 1, 1'b0, 1'b0);

    pulse_walk();
    for (int i = 0; i < 3; i++) timer_cycle("walk1", 0, 1'b0, 1'b0);
    pulse_walk();
    for (int i = 0; i < 7; i++) timer_cycle("walk2", 2, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) timer_cycle("stale", 2, 1'b1, 1'b0);

    for (int i = 0; i < 8 && ph != 4; i++) timer_cycle("to_side", 1, 1'b0, 1'b0);
    check_val("reached_side_g", ph, 4);
    #3 Reset_n = 1'b0;
    ph = 0;
    lat = 1'b0;
    exp_int_a = 6;
    exp_int_b = 12;
    #1;
    check_state("reset_mid", 1'b0);
    walk_req = 1'b1;
    @(posedge clk); #1;
    walk_req = 1'b0;
    check_state("reset_mid_hold", 1'b0);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    expect_entry("rerelease");

    for (int i = 0; i < 40; i++) timer_cycle("random", 2, 1'($urandom_range(0, 1)), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 Parameters SHALL be, one per line:
- T_BASE, 4'd6, base green interval in seconds.
- T_EXT, 4'd3, extension / walk interval in seconds.
- T_YEL, 4'd2, yellow interval in seconds.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  system clock; all state changes on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- sensor  in  1  side-street vehicle present; synchronous, level.
- walk_req  in  1  pedestrian request; synchronous, one-cycle or longer pulse.
- expired  in  1  interval-done strobe from the downstream timer; one cycle wide.
- interval  out  4  seconds value presented to the timer.
- start_timer  out  1  one-cycle timer start strobe.
- main_lights  out  3  main-street lamps {R,Y,G}, one-hot.
- side_lights  out  3  side-street lamps {R,Y,G}, one-hot.
- walk  out  1  pedestrian walk lamp.

Function
REQ-003 The FSM SHALL have exactly six states: MAIN_GB, MAIN_GE, MAIN_Y, WALK, SIDE_G, SIDE_Y.
REQ-004 Lamp decode SHALL be combinational from state:
- MAIN_GB/MAIN_GE: main G, side R.
- MAIN_Y: main Y, side R.
- WALK: both R, walk=1.
- SIDE_G: main R, side G.
- SIDE_Y: main R, side Y.
- walk=0 in every state except WALK.
REQ-005 Every state entry SHALL assert start_timer for exactly one cycle, in the first cycle the new state is held, with interval valid in that same cycle.
REQ-006 Intervals SHALL be:
- MAIN_GB: T_BASE.
- MAIN_GE: T_EXT if sensor=1 on the entry cycle, else T_BASE.
- MAIN_Y: T_YEL.
- WALK: T_EXT.
- SIDE_G: T_BASE+T_EXT if sensor=1 on the entry cycle, else T_BASE.
- SIDE_Y: T_YEL.
REQ-007 The T_BASE+T_EXT sum SHALL be computed 5-bit and saturate to 4'd15.
REQ-008 interval SHALL be registered and held constant for the whole state.
REQ-009 Transitions SHALL occur only on expired=1, registered, so the new state is visible one cycle after the expired strobe:
- MAIN_GB->MAIN_GE
- MAIN_GE->MAIN_Y
- MAIN_Y->WALK if walk latch=1, else SIDE_G
- WALK->SIDE_G
- SIDE_G->SIDE_Y
- SIDE_Y->MAIN_GB
REQ-010 expired SHALL be ignored in any cycle where start_timer=1, to prevent a stale strobe from skipping a state.
REQ-011 walk_req SHALL set a sticky walk latch on any cycle.
REQ-012 The walk latch SHALL clear on the cycle WALK is entered; walk_req asserted during WALK or on the entry cycle SHALL re-set the latch (set wins over clear).
REQ-013 main_lights and side_lights SHALL never both contain G or Y in the same cycle.
REQ-014 Unreachable state encodings SHALL recover to MAIN_GB with start_timer asserted on the next cycle.

Reset
REQ-015 Reset_n=0 SHALL asynchronously force:
- state=MAIN_GB
- walk latch=0
- interval=T_BASE
- start_timer=0
- main_lights=3'b001, side_lights=3'b100, walk=0
REQ-016 On the first rising edge of clk after Reset_n deasserts, start_timer SHALL be 1 for one cycle.
REQ-017 Reset asserted mid-state SHALL abandon the current interval with no residual start_timer or lamp glitch.

Configuration
REQ-018 With macro TLC_WALK_EN defined, the WALK state and the walk latch SHALL exist as specified.
REQ-019 Without TLC_WALK_EN:
- walk_req SHALL be ignored and walk tied to 0.
- MAIN_Y SHALL always go to SIDE_G.
- the WALK state SHALL not be synthesized.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset release, sensor=0, timer model -> start_timer pulses with intervals 6,6,2,6,2 through MAIN_GB..SIDE_Y and back to MAIN_GB.
- sensor=1 held -> MAIN_GE interval=3, SIDE_G interval=9; with T_BASE=12, T_EXT=9, SIDE_G interval=15 (saturated).
- walk_req pulsed during MAIN_GB -> after MAIN_Y expires, WALK entered, walk=1, both R, interval=3, then SIDE_G; with walk_req pulsed during WALK, the next MAIN_Y also goes to WALK.
- expired forced high in the start_timer cycle -> no transition; state changes only on the following strobe.
- Reset_n low mid-SIDE_G -> outputs immediately at reset values; start_timer=1 on first edge after release; built without TLC_WALK_EN -> walk_req ignored, walk stays 0.
